// File: rtl/ctrl_ula.sv
// Three-cycle control unit for an external 8-bit ALU: accepts one instruction,
// drives registered operands, captures the result and writes it back to a 4x8 register file.
module ctrl_ula #(
    parameter logic [7:0] REG_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [15:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_res,
    output logic       done,
    output logic [7:0] done_data,
    output logic       zero,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    localparam logic [2:0] OP_LDI = 3'b111;

    logic [2:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs;
    logic [1:0] in_rt;
    logic [7:0] in_imm;

    // rt and imm share bit 7; each is decoded independently.
    assign in_op  = instr[15:13];
    assign in_rd  = instr[12:11];
    assign in_rs  = instr[10:9];
    assign in_rt  = instr[8:7];
    assign in_imm = instr[7:0];

    state_e     state_q, state_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [1:0] rd_q, rd_d;
    logic [7:0] imm_q, imm_d;
    logic       ldi_q, ldi_d;
    logic       done_q, done_d;
    logic [7:0] done_data_q, done_data_d;
    logic       zero_q, zero_d;
    logic [7:0] result;

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        ldi_d       = ldi_q;
        done_d      = 1'b0;
        done_data_d = done_data_q;
        zero_d      = zero_q;
        result      = ldi_q ? imm_q : alu_res;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d  = EXEC;
                    alu_a_d  = regs_q[in_rs];
                    alu_b_d  = regs_q[in_rt];
                    alu_op_d = (in_op == OP_LDI) ? 3'b000 : in_op;
                    rd_d     = in_rd;
                    imm_d    = in_imm;
                    ldi_d    = (in_op == OP_LDI);
                end
            end
            EXEC: begin
                // done_data doubles as the result register presented during WB.
                state_d     = WB;
                done_d      = 1'b1;
                done_data_d = result;
                zero_d      = (result == 8'h00);
            end
            WB: begin
                state_d       = IDLE;
                regs_d[rd_q]  = done_data_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int unsigned i = 0; i < 4; i++) begin
                regs_q[i] <= REG_RST;
            end
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            ldi_q       <= 1'b0;
            done_q      <= 1'b0;
            done_data_q <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            ldi_q       <= ldi_d;
            done_q      <= done_d;
            done_data_q <= done_data_d;
            zero_q      <= zero_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign done        = done_q;
    assign done_data   = done_data_q;
    assign zero        = zero_q;
    assign dbg_data    = regs_q[dbg_sel];

endmodule

// File: tb/tb_ctrl_ula.sv
// Scoreboard bench for ctrl_ula: directed instructions push hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_ctrl_ula;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_res;
    logic        done;
    logic [7:0]  done_data;
    logic        zero;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int tests;
    int fails;
    int done_cnt;
    logic [7:0] sb [$];

    ctrl_ula #(.REG_RST(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_res     (alu_res),
        .done        (done),
        .done_data   (done_data),
        .zero        (zero),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU
    always_comb begin
        case (alu_op)
            3'b000:  alu_res = alu_a;
            3'b001:  alu_res = alu_a + alu_b;
            3'b010:  alu_res = alu_a & alu_b;
            3'b011:  alu_res = alu_a | alu_b;
            3'b100:  alu_res = alu_a - alu_b;
            3'b101:  alu_res = 8'h00 - alu_a;
            3'b110:  alu_res = ~alu_a;
            default: alu_res = 8'h00;
        endcase
    end

    function automatic logic [15:0] mk_alu(input logic [2:0] op, input logic [1:0] rd,
                                           input logic [1:0] rs, input logic [1:0] rt);
        return {op, rd, rs, rt, 7'd0};
    endfunction

    function automatic logic [15:0] mk_ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {3'b111, rd, 3'b000, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done_data %0h expected no retirement", done_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                chk("done_data", done_data, e);
                chk("zero", zero, (e == 8'h00));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got instr_ready 0 expected 1");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] ins, input logic [7:0] exp_d, input logic chk_ops,
                         input logic [7:0] ea, input logic [7:0] eb, input logic [2:0] eop);
        wait_ready();
        instr       = ins;
        instr_valid = 1'b1;
        sb.push_back(exp_d);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        chk("alu_op", alu_op, eop);
        if (chk_ops) begin
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
        end
    endtask

    task automatic chk_reg(input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        chk($sformatf("R%0d", idx), dbg_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] vec [3];
        logic [7:0]  vexp [3];

        tests = 0; fails = 0; done_cnt = 0;
        rst_n = 1'b0; instr = '0; instr_valid = 1'b0; dbg_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_op", alu_op, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) chk_reg(2'(i), 8'h00);

        // LDI / ADD
        issue(mk_ldi(2'd1, 8'h3C), 8'h3C, 1'b0, 8'h00, 8'h00, 3'b000);
        issue(mk_ldi(2'd2, 8'h05), 8'h05, 1'b0, 8'h00, 8'h00, 3'b000);
        issue(mk_alu(3'b001, 2'd3, 2'd1, 2'd2), 8'h41, 1'b1, 8'h3C, 8'h05, 3'b001);
        drain();
        chk_reg(2'd3, 8'h41);

        // SUB to zero, zero holds in idle
        issue(mk_alu(3'b100, 2'd0, 2'd1, 2'd1), 8'h00, 1'b1, 8'h3C, 8'h3C, 3'b100);
        drain();
        chk("zero_hold", zero, 1);
        issue(mk_alu(3'b101, 2'd2, 2'd2, 2'd0), 8'hFB, 1'b0, 8'h00, 8'h00, 3'b101);
        issue(mk_alu(3'b110, 2'd1, 2'd1, 2'd0), 8'hC3, 1'b0, 8'h00, 8'h00, 3'b110);
        // rd == rs: operands are the pre-write values
        issue(mk_alu(3'b001, 2'd3, 2'd3, 2'd3), 8'h82, 1'b1, 8'h41, 8'h41, 3'b001);
        drain();
        chk_reg(2'd0, 8'h00);
        chk_reg(2'd1, 8'hC3);
        chk_reg(2'd2, 8'hFB);
        chk_reg(2'd3, 8'h82);

        // instr_valid held high across three instructions
        vec[0] = mk_alu(3'b011, 2'd0, 2'd1, 2'd3); vexp[0] = 8'hC3;
        vec[1] = mk_alu(3'b010, 2'd1, 2'd2, 2'd3); vexp[1] = 8'h82;
        vec[2] = mk_alu(3'b000, 2'd2, 2'd0, 2'd0); vexp[2] = 8'hC3;
        wait_ready();
        base = done_cnt;
        instr_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            chk("ready_pattern", instr_ready, (c % 3 == 0));
            if (c % 3 == 0) begin
                instr = vec[c / 3];
                sb.push_back(vexp[c / 3]);
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        drain();
        chk("stream_done_cnt", done_cnt - base, 3);
        chk_reg(2'd2, 8'hC3);

        // instr_valid during EXEC/WB is ignored
        base = done_cnt;
        wait_ready();
        instr = mk_ldi(2'd0, 8'h7F);
        instr_valid = 1'b1;
        sb.push_back(8'h7F);
        @(posedge clk);
        #1;
        instr = mk_alu(3'b001, 2'd3, 2'd1, 2'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("ignore_done_cnt", done_cnt - base, 1);
        chk_reg(2'd0, 8'h7F);
        chk_reg(2'd3, 8'h82);

        // reset during WB aborts LDI R2,AA
        base = done_cnt;
        wait_ready();
        instr = mk_ldi(2'd2, 8'hAA);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_ready", instr_ready, 1);
        chk("abort_done_data", done_data, 8'h00);
        chk_reg(2'd2, 8'h00);
        chk_reg(2'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_done_cnt", done_cnt - base, 0);

        // first accept after reset
        issue(mk_ldi(2'd3, 8'h00), 8'h00, 1'b0, 8'h00, 8'h00, 3'b000);
        issue(mk_ldi(2'd1, 8'h80), 8'h80, 1'b0, 8'h00, 8'h00, 3'b000);
        issue(mk_alu(3'b100, 2'd0, 2'd3, 2'd1), 8'h80, 1'b1, 8'h00, 8'h80, 3'b100);
        drain();
        chk_reg(2'd0, 8'h80);
        chk("final_zero", zero, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
